// File: rtl/video_timing_generator_param.sv
// -----------------------------------------------------------------------------
// video_timing_generator_param
//
// Purpose:
//   A raster timing generator with parameters, whose timing can be reprogrammed
//   at runtime. Horizontal and vertical counters follow an "active" timing set.
//   A new set arrives over a valid/ready config port and is held in a pending
//   (shadow) register. It is copied into the active set only at a frame
//   boundary, or at once while the raster is idle (enable low).
//   Every raster output is registered. Outputs in cycle n reflect the counters
//   in cycle n-1.
//
// Optional feature macro: VTG_LINE_IRQ_EN
//   When defined, this adds the inputs irq_line and irq_en and the output
//   line_irq. line_irq is a one-cycle pulse at the start of line irq_line.
//
// Ports:
//   clk          pixel clock
//   rst_n        synchronous active-low reset
//   enable       run counters; low holds the raster idle at (0,0)
//   cfg_valid    config request
//   cfg_ready    config slot free (no pending config)
//   cfg_h        {hd,hf,hs,hb}, hd in the MSBs
//   cfg_v        {vd,vf,vs,vb}, vd in the MSBs
//   cfg_err      one-cycle pulse: offered config rejected
//   pixel_x/y    coordinate inside the visible area, else 0
//   hsync/vsync  sync outputs, active level set by HS_POL/VS_POL
//   display_en   visible-area flag
//   hblank       h_count >= hd
//   vblank       v_count >= vd
//   line_start   pulse for h_count == 0
//   frame_start  pulse for (h_count, v_count) == (0,0)
//   frame_count  completed frames, wraps
//
// Config handshake:
//   A transfer happens on cfg_valid && cfg_ready in a clock cycle.
//   A legal config is latched into the pending register, and cfg_ready drops
//   in the next cycle. An illegal config is dropped: cfg_err pulses and
//   cfg_ready stays high. cfg_ready returns high in the cycle after the
//   pending set is applied.
// -----------------------------------------------------------------------------
module video_timing_generator_param #(
    parameter int CW     = 12,
    parameter int FCW    = 16,
    parameter int DEF_HD = 640,
    parameter int DEF_HF = 16,
    parameter int DEF_HS = 96,
    parameter int DEF_HB = 48,
    parameter int DEF_VD = 480,
    parameter int DEF_VF = 10,
    parameter int DEF_VS = 2,
    parameter int DEF_VB = 33,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [4*CW-1:0] cfg_h,
    input  logic [4*CW-1:0] cfg_v,
    output logic            cfg_err,
    output logic [CW-1:0]   pixel_x,
    output logic [CW-1:0]   pixel_y,
    output logic            hsync,
    output logic            vsync,
    output logic            display_en,
    output logic            hblank,
    output logic            vblank,
    output logic            line_start,
    output logic            frame_start,
    output logic [FCW-1:0]  frame_count
`ifdef VTG_LINE_IRQ_EN
    ,
    input  logic [CW-1:0]   irq_line,
    input  logic            irq_en,
    output logic            line_irq
`endif
);

    // Totals are carried in CW+1 bits. Incoming sums use CW+2 bits, because
    // four CW-bit fields can reach almost 4*2^CW before the range check.
    localparam int TW = CW + 1;
    localparam int EW = CW + 2;
    localparam logic [EW-1:0] TOT_MAX = EW'(1) << CW;

    localparam logic [CW-1:0] D_HD = CW'(DEF_HD);
    localparam logic [CW-1:0] D_HF = CW'(DEF_HF);
    localparam logic [CW-1:0] D_HS = CW'(DEF_HS);
    localparam logic [CW-1:0] D_HB = CW'(DEF_HB);
    localparam logic [CW-1:0] D_VD = CW'(DEF_VD);
    localparam logic [CW-1:0] D_VF = CW'(DEF_VF);
    localparam logic [CW-1:0] D_VS = CW'(DEF_VS);
    localparam logic [CW-1:0] D_VB = CW'(DEF_VB);

    // ------------------------------------------------------------------
    // Timing registers: the active set, and the pending set from the port
    // ------------------------------------------------------------------
    logic [CW-1:0] act_hd, act_hf, act_hs, act_hb;
    logic [CW-1:0] act_vd, act_vf, act_vs, act_vb;
    logic [CW-1:0] pend_hd, pend_hf, pend_hs, pend_hb;
    logic [CW-1:0] pend_vd, pend_vf, pend_vs, pend_vb;
    logic          pend_valid;

    // Raster counters and the internal completed-frame counter
    logic [CW-1:0]  h_count;
    logic [CW-1:0]  v_count;
    logic [FCW-1:0] frame_cnt;

    // ------------------------------------------------------------------
    // Incoming config decode and legality check
    // ------------------------------------------------------------------
    logic [CW-1:0] in_hd, in_hf, in_hs, in_hb;
    logic [CW-1:0] in_vd, in_vf, in_vs, in_vb;
    logic [EW-1:0] in_htot, in_vtot;
    logic          cfg_bad;
    logic          cfg_fire;

    assign in_hd = cfg_h[4*CW-1 -: CW];
    assign in_hf = cfg_h[3*CW-1 -: CW];
    assign in_hs = cfg_h[2*CW-1 -: CW];
    assign in_hb = cfg_h[CW-1:0];
    assign in_vd = cfg_v[4*CW-1 -: CW];
    assign in_vf = cfg_v[3*CW-1 -: CW];
    assign in_vs = cfg_v[2*CW-1 -: CW];
    assign in_vb = cfg_v[CW-1:0];

    assign in_htot = EW'(in_hd) + EW'(in_hf) + EW'(in_hs) + EW'(in_hb);
    assign in_vtot = EW'(in_vd) + EW'(in_vf) + EW'(in_vs) + EW'(in_vb);

    // A zero display or sync width gives no usable raster. A total above
    // 2^CW cannot be reached by a CW-bit counter.
    assign cfg_bad = (in_hd == '0) || (in_hs == '0) ||
                     (in_vd == '0) || (in_vs == '0) ||
                     (in_htot > TOT_MAX) || (in_vtot > TOT_MAX);

    // The slot is free whenever nothing is pending
    assign cfg_ready = ~pend_valid;
    assign cfg_fire  = cfg_valid && cfg_ready;

    // ------------------------------------------------------------------
    // Derived totals and raster position decode
    // ------------------------------------------------------------------
    logic [TW-1:0] htot, vtot;
    logic [TW-1:0] h_ext, v_ext;
    logic [TW-1:0] hs_lo, hs_hi, vs_lo, vs_hi;
    logic          h_last, v_last;
    logic          frame_end;
    logic          apply_now;

    assign htot  = TW'(act_hd) + TW'(act_hf) + TW'(act_hs) + TW'(act_hb);
    assign vtot  = TW'(act_vd) + TW'(act_vf) + TW'(act_vs) + TW'(act_vb);
    assign h_ext = TW'(h_count);
    assign v_ext = TW'(v_count);

    assign h_last    = (h_ext == htot - TW'(1));
    assign v_last    = (v_ext == vtot - TW'(1));
    assign frame_end = enable && h_last && v_last;

    // Pending timing takes over as the last pixel of a frame ends, so the
    // counters wrap straight into the new geometry. When idle, the counters
    // already sit at (0,0), so the new timing can be applied at once.
    assign apply_now = pend_valid && (frame_end || !enable);

    assign hs_lo = TW'(act_hd) + TW'(act_hf);
    assign hs_hi = hs_lo + TW'(act_hs);
    assign vs_lo = TW'(act_vd) + TW'(act_vf);
    assign vs_hi = vs_lo + TW'(act_vs);

    // ------------------------------------------------------------------
    // Config path: pending capture, apply, error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_hd     <= D_HD;
            act_hf     <= D_HF;
            act_hs     <= D_HS;
            act_hb     <= D_HB;
            act_vd     <= D_VD;
            act_vf     <= D_VF;
            act_vs     <= D_VS;
            act_vb     <= D_VB;
            pend_hd    <= '0;
            pend_hf    <= '0;
            pend_hs    <= '0;
            pend_hb    <= '0;
            pend_vd    <= '0;
            pend_vf    <= '0;
            pend_vs    <= '0;
            pend_vb    <= '0;
            pend_valid <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= cfg_fire && cfg_bad;
            // apply_now and cfg_fire are mutually exclusive: apply needs a
            // pending set, which holds cfg_ready low.
            if (apply_now) begin
                act_hd     <= pend_hd;
                act_hf     <= pend_hf;
                act_hs     <= pend_hs;
                act_hb     <= pend_hb;
                act_vd     <= pend_vd;
                act_vf     <= pend_vf;
                act_vs     <= pend_vs;
                act_vb     <= pend_vb;
                pend_valid <= 1'b0;
            end else if (cfg_fire && !cfg_bad) begin
                pend_hd    <= in_hd;
                pend_hf    <= in_hf;
                pend_hs    <= in_hs;
                pend_hb    <= in_hb;
                pend_vd    <= in_vd;
                pend_vf    <= in_vf;
                pend_vs    <= in_vs;
                pend_vb    <= in_vb;
                pend_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_count   <= '0;
            v_count   <= '0;
            frame_cnt <= '0;
        end else if (!enable) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_last) begin
            h_count <= '0;
            if (v_last) begin
                v_count   <= '0;
                frame_cnt <= frame_cnt + FCW'(1);
            end else begin
                v_count <= v_count + CW'(1);
            end
        end else begin
            h_count <= h_count + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Next-value decode for the registered outputs
    // ------------------------------------------------------------------
    logic          h_vis, v_vis, vis;
    logic          nxt_hsync, nxt_vsync;
    logic          nxt_disp, nxt_hblank, nxt_vblank;
    logic          nxt_lstart, nxt_fstart;
    logic [CW-1:0] nxt_px, nxt_py;
`ifdef VTG_LINE_IRQ_EN
    logic          nxt_irq;
`endif

    assign h_vis = (h_ext < TW'(act_hd));
    assign v_vis = (v_ext < TW'(act_vd));
    assign vis   = h_vis && v_vis;

    always_comb begin
        nxt_px     = '0;
        nxt_py     = '0;
        nxt_disp   = 1'b0;
        nxt_hblank = 1'b1;
        nxt_vblank = 1'b1;
        nxt_hsync  = ~HS_POL;
        nxt_vsync  = ~VS_POL;
        nxt_lstart = 1'b0;
        nxt_fstart = 1'b0;
`ifdef VTG_LINE_IRQ_EN
        nxt_irq    = 1'b0;
`endif
        if (enable) begin
            nxt_disp   = vis;
            nxt_px     = vis ? h_count : '0;
            nxt_py     = vis ? v_count : '0;
            nxt_hblank = ~h_vis;
            nxt_vblank = ~v_vis;
            nxt_hsync  = ((h_ext >= hs_lo) && (h_ext < hs_hi)) ? HS_POL : ~HS_POL;
            nxt_vsync  = ((v_ext >= vs_lo) && (v_ext < vs_hi)) ? VS_POL : ~VS_POL;
            nxt_lstart = (h_count == '0);
            nxt_fstart = (h_count == '0) && (v_count == '0);
`ifdef VTG_LINE_IRQ_EN
            // v_count never reaches vtot, so irq_line >= vtot cannot match
            nxt_irq    = irq_en && (h_count == '0) && (v_count == irq_line);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            display_en  <= 1'b0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
`ifdef VTG_LINE_IRQ_EN
            line_irq    <= 1'b0;
`endif
        end else begin
            pixel_x     <= nxt_px;
            pixel_y     <= nxt_py;
            display_en  <= nxt_disp;
            hblank      <= nxt_hblank;
            vblank      <= nxt_vblank;
            hsync       <= nxt_hsync;
            vsync       <= nxt_vsync;
            line_start  <= nxt_lstart;
            frame_start <= nxt_fstart;
            // Delayed with the other outputs so the count advances on the
            // same cycle that frame_start opens the next frame.
            frame_count <= frame_cnt;
`ifdef VTG_LINE_IRQ_EN
            line_irq    <= nxt_irq;
`endif
        end
    end

endmodule

// File: tb/tb_video_timing_generator_param.sv
// Directed testbench for video_timing_generator_param. It uses a reduced
// default geometry (25x13 clocks) so that whole frames stay short.
module tb_video_timing_generator_param;
    localparam int CW  = 12;
    localparam int FCW = 16;

    logic            clk = 1'b0;
    logic            rst_n, enable, cfg_valid;
    logic [4*CW-1:0] cfg_h, cfg_v;
    logic            cfg_ready, cfg_err;
    logic [CW-1:0]   pixel_x, pixel_y;
    logic            hsync, vsync, display_en, hblank, vblank;
    logic            line_start, frame_start;
    logic [FCW-1:0]  frame_count;
`ifdef VTG_LINE_IRQ_EN
    logic [CW-1:0]   irq_line;
    logic            irq_en;
    logic            line_irq;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    video_timing_generator_param #(
        .CW(CW), .FCW(FCW),
        .DEF_HD(16), .DEF_HF(2), .DEF_HS(4), .DEF_HB(3),
        .DEF_VD(8),  .DEF_VF(1), .DEF_VS(2), .DEF_VB(2),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_err(cfg_err),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .hsync(hsync), .vsync(vsync), .display_en(display_en),
        .hblank(hblank), .vblank(vblank),
        .line_start(line_start), .frame_start(frame_start),
        .frame_count(frame_count)
`ifdef VTG_LINE_IRQ_EN
        , .irq_line(irq_line), .irq_en(irq_en), .line_irq(line_irq)
`endif
    );

    function automatic logic [4*CW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {CW'(a), CW'(b), CW'(c), CW'(d)};
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " cfg_ready"}, cfg_ready, 1);
        check({tag, " cfg_err"}, cfg_err, 0);
        check({tag, " pixel_x"}, pixel_x, 0);
        check({tag, " pixel_y"}, pixel_y, 0);
        check({tag, " display_en"}, display_en, 0);
        check({tag, " line_start"}, line_start, 0);
        check({tag, " frame_start"}, frame_start, 0);
        check({tag, " frame_count"}, frame_count, 0);
        check({tag, " hblank"}, hblank, 0);
        check({tag, " vblank"}, vblank, 0);
        check({tag, " hsync"}, hsync, 1);
        check({tag, " vsync"}, vsync, 1);
`ifdef VTG_LINE_IRQ_EN
        check({tag, " line_irq"}, line_irq, 0);
`endif
    endtask

    // Walk one whole frame from the negedge where frame_start is high.
    // Index i of the frame maps to h = i % htot and v = i / htot.
    // The task ends on the first negedge of the following frame.
    task automatic scan_frame(input string tag,
                              input int hd, input int hf, input int hs, input int hb,
                              input int vd, input int vf, input int vs, input int vb,
                              input int fc, input int exp_disp, input int exp_hs_low,
                              input int exp_irq);
        int ht, vt, h, v;
        int e_disp, e_px, e_py, e_hs, e_vs, e_hb, e_vb, e_ls, e_fs, e_fc, e_irq;
        int n_disp, n_hs, n_irq;
        logic x_disp, x_hs, x_vs;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        e_disp = 0; e_px = 0; e_py = 0; e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0;
        e_ls = 0; e_fs = 0; e_fc = 0; e_irq = 0; n_disp = 0; n_hs = 0; n_irq = 0;
        for (int i = 0; i < ht * vt; i++) begin
            h = i % ht;
            v = i / ht;
            x_disp = (h < hd) && (v < vd);
            x_hs = !((h >= hd + hf) && (h < hd + hf + hs));
            x_vs = !((v >= vd + vf) && (v < vd + vf + vs));
            if (display_en !== x_disp) e_disp++;
            if (pixel_x !== CW'(x_disp ? h : 0)) e_px++;
            if (pixel_y !== CW'(x_disp ? v : 0)) e_py++;
            if (hsync !== x_hs) e_hs++;
            if (vsync !== x_vs) e_vs++;
            if (hblank !== logic'(h >= hd)) e_hb++;
            if (vblank !== logic'(v >= vd)) e_vb++;
            if (line_start !== logic'(h == 0)) e_ls++;
            if (frame_start !== logic'(i == 0)) e_fs++;
            if (frame_count !== FCW'(fc)) e_fc++;
`ifdef VTG_LINE_IRQ_EN
            if (line_irq !== logic'(irq_en && h == 0 && v == int'(irq_line))) e_irq++;
            if (line_irq === 1'b1) n_irq++;
`endif
            if (display_en === 1'b1) n_disp++;
            if (hsync === 1'b0) n_hs++;
            @(negedge clk);
        end
        check({tag, " display_en cycles wrong"}, e_disp, 0);
        check({tag, " pixel_x cycles wrong"}, e_px, 0);
        check({tag, " pixel_y cycles wrong"}, e_py, 0);
        check({tag, " hsync cycles wrong"}, e_hs, 0);
        check({tag, " vsync cycles wrong"}, e_vs, 0);
        check({tag, " hblank cycles wrong"}, e_hb, 0);
        check({tag, " vblank cycles wrong"}, e_vb, 0);
        check({tag, " line_start cycles wrong"}, e_ls, 0);
        check({tag, " frame_start cycles wrong"}, e_fs, 0);
        check({tag, " frame_count cycles wrong"}, e_fc, 0);
        check({tag, " visible clocks"}, n_disp, exp_disp);
        check({tag, " hsync low clocks"}, n_hs, exp_hs_low);
`ifdef VTG_LINE_IRQ_EN
        check({tag, " line_irq cycles wrong"}, e_irq, 0);
        check({tag, " line_irq pulses"}, n_irq, exp_irq);
`else
        if (exp_irq < 0) $display("[TB] unexpected irq count");
`endif
        check({tag, " next frame_start"}, frame_start, 1);
    endtask

    // Watchdog: the run is about 10k clocks
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic r1, r2;
        logic [4*CW-1:0] bad_h[6];
        logic [4*CW-1:0] bad_v[6];

        rst_n = 1'b0; enable = 1'b1; cfg_valid = 1'b0; cfg_h = '0; cfg_v = '0;
`ifdef VTG_LINE_IRQ_EN
        irq_line = CW'(10); irq_en = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check_reset("reset");

        // Release reset: counters sit at (0,0), so frame_start shows one edge later
        rst_n = 1'b1;
        @(negedge clk);
        check("first frame_start", frame_start, 1);
        // Default geometry 25x13: 128 visible clocks, 4*13 hsync clocks, irq at line 10
        scan_frame("frame0 default", 16, 2, 4, 3, 8, 1, 2, 2, 0, 128, 52, 1);
        check("frame_count after first wrap", frame_count, 1);

        // Config offered mid-frame: the current frame keeps 25x13
        repeat (60) @(negedge clk);
        check("cfg_ready before offer", cfg_ready, 1);
        cfg_h = pack4(320, 8, 48, 24);
        cfg_v = pack4(6, 1, 1, 2);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        // Values held without cfg_valid must not matter
        cfg_h = pack4(5, 1, 1, 1);
        cfg_v = pack4(3, 1, 1, 1);
        check("cfg_ready drops after accept", cfg_ready, 0);
        check("cfg_err after good cfg", cfg_err, 0);
        n = 0; r1 = cfg_ready; r2 = cfg_ready;
        while (frame_start !== 1'b1 && n < 1000) begin
            r2 = r1;
            r1 = cfg_ready;
            @(negedge clk);
            n++;
        end
        check("old frame remainder length", n, 264);
        check("cfg_ready before apply", r2, 0);
        check("cfg_ready after apply", r1, 1);
        check("frame_count frame2", frame_count, 2);
        // New geometry 400x10: 320*6 visible clocks, 48*10 hsync clocks, line 10 absent
        scan_frame("frame2 new 400x10", 320, 8, 48, 24, 6, 1, 1, 2, 2, 1920, 480, 0);

        // Illegal configs: hs=0, htot=4097, vd=0, vs=0, vtot=4097, hd=0
        bad_h[0] = pack4(100, 4, 0, 4);      bad_v[0] = pack4(6, 1, 1, 2);
        bad_h[1] = pack4(4000, 32, 32, 33);  bad_v[1] = pack4(6, 1, 1, 2);
        bad_h[2] = pack4(320, 8, 48, 24);    bad_v[2] = pack4(0, 1, 1, 2);
        bad_h[3] = pack4(320, 8, 48, 24);    bad_v[3] = pack4(6, 1, 0, 2);
        bad_h[4] = pack4(320, 8, 48, 24);    bad_v[4] = pack4(4000, 40, 40, 17);
        bad_h[5] = pack4(0, 8, 48, 24);      bad_v[5] = pack4(6, 1, 1, 2);
        repeat (100) @(negedge clk);
        cfg_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cfg_h = bad_h[k];
            cfg_v = bad_v[k];
            @(negedge clk);
            check($sformatf("reject %0d cfg_err", k), cfg_err, 1);
            check($sformatf("reject %0d cfg_ready", k), cfg_ready, 1);
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        check("cfg_err clears", cfg_err, 0);
        check("cfg_ready after rejects", cfg_ready, 1);
        n = 0;
        while (frame_start !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("frame3 remainder after rejects", n, 3893);
        check("frame_count frame4", frame_count, 4);
        scan_frame("frame4 unchanged", 320, 8, 48, 24, 6, 1, 1, 2, 4, 1920, 480, 0);

        // Reset mid-frame while a config is pending
        cfg_h = pack4(10, 2, 3, 2);
        cfg_v = pack4(6, 1, 1, 2);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("pending before reset", cfg_ready, 0);
        repeat (500) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("mid reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("frame_start after mid reset", frame_start, 1);
        scan_frame("post-reset default", 16, 2, 4, 3, 8, 1, 2, 2, 0, 128, 52, 1);
        check("pending discarded", cfg_ready, 1);

        // enable low for 100 cycles mid-line (line 1, h=5)
        repeat (30) @(negedge clk);
        enable = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (hsync !== 1'b1 || vsync !== 1'b1 || display_en !== 1'b0 ||
                hblank !== 1'b1 || vblank !== 1'b1 || line_start !== 1'b0 ||
                frame_start !== 1'b0 || frame_count !== FCW'(1) ||
                pixel_x !== '0 || pixel_y !== '0) n++;
        end
        check("idle outputs wrong cycles", n, 0);
        enable = 1'b1;
        @(negedge clk);
        check("frame_start after enable", frame_start, 1);
        check("frame_count frozen", frame_count, 1);
        scan_frame("after enable", 16, 2, 4, 3, 8, 1, 2, 2, 1, 128, 52, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/video_timing_generator_param.md
Name: video_timing_generator_param

Overview:
- Parametrised, runtime-reprogrammable raster timing generator for the video pipeline. Drives the pixel fetch, scan-out and display-output blocks.
- Replaces the fixed 640x480@60 generator. Timing comes from a shadow register set loaded over a valid/ready config port; the new set takes effect only at a frame boundary.
- Adds blanking flags, line/frame strobes, a frame counter and sync polarity selection.

Parameters:
- CW, 12, width of the counter, coordinate and config fields.
- FCW, 16, width of frame_count.
- DEF_HD / DEF_HF / DEF_HS / DEF_HB, 640 / 16 / 96 / 48, reset horizontal display / front porch / sync / back porch (pixels).
- DEF_VD / DEF_VF / DEF_VS / DEF_VB, 480 / 10 / 2 / 33, reset vertical display / front porch / sync / back porch (lines).
- HS_POL, 0, active level of hsync (0 = active low).
- VS_POL, 0, active level of vsync.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  run counters; low holds the raster at (0,0) idle
- cfg_valid  in  1  config request
- cfg_ready  out  1  config slot free
- cfg_h  in  4*CW  {hd,hf,hs,hb}, hd in MSBs
- cfg_v  in  4*CW  {vd,vf,vs,vb}, vd in MSBs
- cfg_err  out  1  one-cycle pulse: config rejected
- pixel_x  out  CW  h coordinate inside display, else 0
- pixel_y  out  CW  v coordinate inside display, else 0
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- display_en  out  1  visible-area flag
- hblank  out  1  h_count >= hd
- vblank  out  1  v_count >= vd
- line_start  out  1  pulse when h_count == 0
- frame_start  out  1  pulse when h_count == 0 and v_count == 0
- frame_count  out  FCW  completed frames, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - Counters and pending register cleared.
  - Active timing = DEF_* parameters.
  - cfg_ready = 1, cfg_err = 0.
  - pixel_x/y = 0, display_en = 0, line_start = 0, frame_start = 0, frame_count = 0.
  - hblank = 0, vblank = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL.
- Derived totals: htot = hd+hf+hs+hb and vtot = vd+vf+vs+vb, computed in CW+1 bits.
- Counting:
  - h_count runs 0..htot-1. v_count increments when h_count == htot-1 and wraps after vtot-1.
  - frame_count increments on the (htot-1, vtot-1) cycle.
- Output latency: every output is registered one cycle after the counters, so outputs at cycle n reflect the counters at cycle n-1.
  - hsync is active for h in [hd+hf, hd+hf+hs).
  - vsync is active for v in [vd+vf, vd+vf+vs).
- enable low:
  - Counters forced to 0 on the next edge.
  - display_en, line_start and frame_start = 0; syncs inactive; blank flags = 1; frame_count holds.
- enable rising: the first counted cycle is (0,0), so frame_start pulses one cycle later.
- Config handshake:
  - Transfer occurs on cfg_valid && cfg_ready. A valid config is latched into the pending register and cfg_ready drops on the next cycle.
  - Rejection: a config with hd == 0, hs == 0, vd == 0, vs == 0, htot > 2^CW or vtot > 2^CW is not latched. cfg_err pulses for one cycle and cfg_ready stays 1.
- Config apply:
  - Pending is copied into the active set on the (htot-1, vtot-1) cycle, so the new frame starts with new timing. If enable is low, pending applies on the next cycle instead.
  - cfg_ready returns to 1 the cycle after the apply.
  - A transfer on the apply cycle itself is impossible, because cfg_ready = 0 then.
- Mid-operation reset: synchronous and complete. The pending config is discarded and the DEF_* timing is restored.
- Configs held in cfg_h/cfg_v without cfg_valid have no effect.

Optional Feature:
- Macro: VTG_LINE_IRQ_EN.
- When defined, adds:
  - input irq_line [CW]
  - input irq_en [1]
  - output line_irq [1]: one-cycle pulse, registered alongside line_start, when h_count == 0 and v_count == irq_line and irq_en == 1. irq_line >= vtot never fires. Reset value 0.
- When undefined, these ports and their logic are absent.

Test Plan:
- Default timing after reset, enable = 1:
  - 800 clocks per line, 525 lines per frame; frame_start period 420000 clocks.
  - hsync low for exactly 96 clocks, starting one cycle after h_count == 656.
  - frame_count = 1 after the first wrap.
- Visible area:
  - display_en high for 640 clocks per line on lines 0..479.
  - pixel_x sequence 0..639 then 0.
  - vblank high on lines 480..524.
- Config mid-frame, cfg_h = {320,8,48,24}, cfg_v = {240,5,1,16}:
  - cfg_ready drops the next cycle; the current frame keeps 800x525.
  - The next frame is 400x262; cfg_ready returns 1 after the apply.
- Invalid config, hs = 0, with cfg_valid = 1:
  - cfg_err pulses one cycle, cfg_ready stays 1, timing unchanged.
- Reset asserted mid-frame with a pending config:
  - Next cycle all outputs hold their reset values, timing reverts to 640x480, pending is discarded.
- enable low for 100 cycles mid-line, then high:
  - Syncs inactive, frame_count frozen.
  - frame_start pulses one cycle after the first counted (0,0) cycle.
  - With VTG_LINE_IRQ_EN defined, irq_line = 10: line_irq pulses once per frame, at line 10.
